r2b_block_streamer: RTL and testbench

R2B_BLOCK_STREAMER -- requirements
Module: r2b_block_streamer

---
 rtl/r2b_block_streamer_pkg.sv | 36 +++
 rtl/r2b_block_streamer_row_buffer_mr.sv | 55 +++++
 rtl/r2b_block_streamer.sv | 252 +++++++++++++++++++++++++
 tb/tb_r2b_block_streamer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/r2b_block_streamer_pkg.sv
// Shared definitions for the row-to-block streamer.
// Holds the FSM state encoding and helpers that derive frame geometry
// (block-row groups, block columns, beats per frame) and counter widths
// from the block parameters.
package r2b_block_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Output skid buffer depth: one entry covers the in-flight read, the
    // other absorbs a stall without dropping throughput.
    localparam int SKID_DEPTH = 2;

    function automatic int block_row_groups(input int rows, input int block_rows, input int cores);
        return rows / block_rows / cores;
    endfunction

    function automatic int block_cols(input int cols, input int block_cols_p);
        return cols / block_cols_p;
    endfunction

    function automatic int beats_per_frame(input int rows, input int cols, input int block_rows,
                                           input int block_cols_p, input int cores);
        return block_row_groups(rows, block_rows, cores) * block_cols(cols, block_cols_p);
    endfunction

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/r2b_block_streamer_row_buffer_mr.sv
// Frame row store for the streamer.
// One write port takes a whole matrix row; NPORT synchronous read ports
// each return the BLOCK_COLS-element slice of one row selected by a block
// column index, with element k placed at bits [k*WIDTH +: WIDTH].
// Ports: clk; wr_en/wr_addr/wr_data (write); rd_addr (NPORT packed row
// addresses), rd_col (block column), rd_data (NPORT packed slices, 1-cycle latency).
module row_buffer_mr #(
    parameter int WIDTH      = 16,
    parameter int COL        = 64,
    parameter int DEPTH      = 256,
    parameter int BLOCK_COLS = 4,
    parameter int NPORT      = 2,
    parameter int AW         = 8,
    parameter int CW         = 4
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [AW-1:0]                     wr_addr,
    input  logic [WIDTH*COL-1:0]              wr_data,
    input  logic [NPORT*AW-1:0]               rd_addr,
    input  logic [CW-1:0]                     rd_col,
    output logic [NPORT*WIDTH*BLOCK_COLS-1:0] rd_data
);
    localparam int BW = WIDTH * BLOCK_COLS;

    logic [WIDTH*COL-1:0]  mem_q [DEPTH];
    logic [NPORT*BW-1:0]   rd_data_d;
    logic [NPORT*BW-1:0]   rd_data_q;

    // Row storage write port (contents need no reset).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Select the block-column slice of each addressed row; column 0 is the row MSB.
    always_comb begin
        rd_data_d = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int k = 0; k < BLOCK_COLS; k++) begin
                rd_data_d[p*BW + k*WIDTH +: WIDTH] =
                    mem_q[rd_addr[p*AW +: AW]][(COL - 1 - (int'(rd_col) * BLOCK_COLS + k)) * WIDTH +: WIDTH];
            end
        end
    end

    // Read data register giving the one-cycle read latency.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/r2b_block_streamer.sv
// Row-to-block streamer: buffers a ROW x COL frame arriving one row per
// accept, then streams it out as BLOCK_ROWS x BLOCK_COLS blocks, NUM_CORES
// consecutive block rows per beat, block-row index inner, block column outer.
// Ports: clk, rst_n (async active-low); start; in_valid/in_ready/in_row
// (row input, column 0 in MSBs); out_valid/out_ready/out_data/out_last
// (block output); busy (FILL or DRAIN); done (one-cycle completion pulse).
module r2b_block_streamer
    import r2b_block_streamer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ROW        = 256,
    parameter int COL        = 64,
    parameter int BLOCK_ROWS = 2,
    parameter int BLOCK_COLS = 4,
    parameter int NUM_CORES  = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [WIDTH*COL-1:0]                           in_row,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [WIDTH*BLOCK_ROWS*BLOCK_COLS*NUM_CORES-1:0] out_data,
    output logic                                           out_last,
    output logic                                           busy,
    output logic                                           done
);
    localparam int NGRP   = block_row_groups(ROW, BLOCK_ROWS, NUM_CORES);
    localparam int NBCOL  = block_cols(COL, BLOCK_COLS);
    localparam int NBEATS = beats_per_frame(ROW, COL, BLOCK_ROWS, BLOCK_COLS, NUM_CORES);
    localparam int NPORT  = BLOCK_ROWS * NUM_CORES;
    localparam int AW     = cnt_width(ROW);
    localparam int GW     = cnt_width(NGRP);
    localparam int CW     = cnt_width(NBCOL);
    localparam int BCW    = cnt_width(NBEATS + 1);
    localparam int DW     = WIDTH * BLOCK_ROWS * BLOCK_COLS * NUM_CORES;

    generate
        if ((ROW % BLOCK_ROWS) != 0 || (COL % BLOCK_COLS) != 0 ||
            ((ROW / BLOCK_ROWS) % NUM_CORES) != 0) begin : g_bad_geometry
            $error("r2b_block_streamer: frame does not tile into whole beats");
        end
    endgenerate

    state_t            state_q,     state_d;
    logic [AW-1:0]     row_cnt_q,   row_cnt_d;
    logic [GW-1:0]     grp_q,       grp_d;
    logic [CW-1:0]     bcol_q,      bcol_d;
    logic [BCW-1:0]    issued_q,    issued_d;
    logic              rd_vld_q,    rd_vld_d;
    logic              rd_last_q,   rd_last_d;
    logic [1:0]        occ_q,       occ_d;
    logic [DW-1:0]     slot0_q,     slot0_d;
    logic [DW-1:0]     slot1_q,     slot1_d;
    logic              last0_q,     last0_d;
    logic              last1_q,     last1_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic              accept_s;
    logic              pop_s;
    logic              issue_s;
    logic [2:0]        credit_s;
    logic [1:0]        occ_pop_s;
    logic [NPORT*AW-1:0] rd_addr_s;
    logic [DW-1:0]     rd_data_s;

    row_buffer_mr #(
        .WIDTH      (WIDTH),
        .COL        (COL),
        .DEPTH      (ROW),
        .BLOCK_COLS (BLOCK_COLS),
        .NPORT      (NPORT),
        .AW         (AW),
        .CW         (CW)
    ) u_row_buffer (
        .clk     (clk),
        .wr_en   (accept_s),
        .wr_addr (row_cnt_q),
        .wr_data (in_row),
        .rd_addr (rd_addr_s),
        .rd_col  (bcol_q),
        .rd_data (rd_data_s)
    );

    // Next-state, read issue and skid buffer bookkeeping.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        grp_d     = grp_q;
        bcol_d    = bcol_q;
        issued_d  = issued_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        last0_d   = last0_q;
        last1_d   = last1_q;

        accept_s = in_valid & in_ready_q;
        pop_s    = out_valid_q & out_ready;

        // Credits count buffered plus in-flight beats; a beat leaving this
        // cycle frees its slot immediately so full rate is kept.
        credit_s = {1'b0, occ_q} + {2'b00, rd_vld_q} - {2'b00, pop_s};
        issue_s  = (state_q == ST_DRAIN) && (issued_q != BCW'(NBEATS)) && (credit_s < 3'd2);

        for (int c = 0; c < NUM_CORES; c++) begin
            for (int r = 0; r < BLOCK_ROWS; r++) begin
                rd_addr_s[(c*BLOCK_ROWS + r)*AW +: AW] =
                    AW'((int'(grp_q) * NUM_CORES + c) * BLOCK_ROWS + r);
            end
        end

        rd_vld_d  = issue_s;
        rd_last_d = issue_s && (issued_q == BCW'(NBEATS - 1));

        if (issue_s) begin
            issued_d = issued_q + BCW'(1);
            if (grp_q == GW'(NGRP - 1)) begin
                grp_d = GW'(0);
                if (bcol_q == CW'(NBCOL - 1)) begin
                    bcol_d = CW'(0);
                end else begin
                    bcol_d = bcol_q + CW'(1);
                end
            end else begin
                grp_d = grp_q + GW'(1);
            end
        end else begin
            issued_d = issued_q;
        end

        // Head slot always drives the outputs; a pop shifts slot1 forward.
        occ_pop_s = occ_q - {1'b0, pop_s};
        if (pop_s) begin
            slot0_d = slot1_q;
            last0_d = last1_q;
        end else begin
            slot0_d = slot0_q;
        end
        if (rd_vld_q) begin
            if (occ_pop_s == 2'd0) begin
                slot0_d = rd_data_s;
                last0_d = rd_last_q;
            end else begin
                slot1_d = rd_data_s;
                last1_d = rd_last_q;
            end
        end else begin
            slot1_d = slot1_q;
        end
        occ_d = occ_pop_s + {1'b0, rd_vld_q};
        if (occ_d == 2'd0) begin
            last0_d = 1'b0;
        end else begin
            last0_d = last0_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FILL;
                    row_cnt_d = '0;
                    grp_d     = '0;
                    bcol_d    = '0;
                    issued_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    if (row_cnt_q == AW'(ROW - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + AW'(1);
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (pop_s && last0_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (occ_d != 2'd0);
        in_ready_d  = (state_d == ST_FILL);
        busy_d      = (state_d == ST_FILL) || (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
    end

    // State, counters, skid buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            grp_q       <= '0;
            bcol_q      <= '0;
            issued_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            occ_q       <= 2'd0;
            slot0_q     <= '0;
            slot1_q     <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            grp_q       <= grp_d;
            bcol_q      <= bcol_d;
            issued_q    <= issued_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            occ_q       <= occ_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = slot0_q;
    assign out_last  = last0_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_r2b_block_streamer.sv
// Self-checking bench for r2b_block_streamer with an 8x8 frame, 2x4 blocks
// and two lanes per beat. Expected beats come from a direct element-index
// model over the frame matrix held in the bench.
module tb_r2b_block_streamer;
    localparam int WIDTH  = 16;
    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int BR     = 2;
    localparam int BC     = 4;
    localparam int NC     = 2;
    localparam int NGRP   = ROW / BR / NC;
    localparam int NBEATS = NGRP * (COL / BC);
    localparam int DW     = WIDTH * BR * BC * NC;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH*COL-1:0]   in_row = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [DW-1:0]          out_data;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    r2b_block_streamer #(
        .WIDTH(WIDTH), .ROW(ROW), .COL(COL),
        .BLOCK_ROWS(BR), .BLOCK_COLS(BC), .NUM_CORES(NC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] mat [ROW][COL];
    logic [DW-1:0]    got_data [$];
    bit               got_last [$];
    int acc_cnt, lat, done_cycle, last_edge, done_pulses, stab_err, timeout;

    task automatic set_matrix(input int mode, input int offset);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                mat[r][c] = (mode == 0) ? WIDTH'(r*16 + c + offset) : WIDTH'($urandom_range(0, 65535));
    endtask

    function automatic logic [WIDTH*COL-1:0] row_bits(input int r);
        logic [WIDTH*COL-1:0] v = '0;
        for (int c = 0; c < COL; c++) v[(COL-1-c)*WIDTH +: WIDTH] = mat[r][c];
        return v;
    endfunction

    // Beat b covers block column b/NGRP and block-row group b%NGRP.
    function automatic logic [DW-1:0] exp_beat(input int b);
        logic [DW-1:0] v = '0;
        int bcol = b / NGRP;
        int grp  = b % NGRP;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < BR; r++)
                for (int k = 0; k < BC; k++)
                    v[((c*BR + r)*BC + k)*WIDTH +: WIDTH] = mat[(grp*NC + c)*BR + r][bcol*BC + k];
        return v;
    endfunction

    // Drive one frame and record what comes out.
    // vmode: 0 in_valid always, 1 random gaps. rmode: 0 ready always, 1 alternating, 2 random.
    task automatic run_frame(input int vmode, input int rmode, input bit noise, input int abort_after);
        int cyc = 0;
        int rows = 0;
        int acc_edge = -100;
        bit seen_v = 1'b0;
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        got_data.delete(); got_last.delete();
        acc_cnt = 0; lat = -1; done_cycle = -1; last_edge = -1; done_pulses = 0; stab_err = 0; timeout = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) stab_err++;
            if (out_valid && !seen_v) begin seen_v = 1'b1; lat = cyc - acc_edge; end
            if (done) begin done_pulses++; if (done_cycle < 0) done_cycle = cyc; end
            if (done_cycle >= 0 && cyc > done_cycle) break;
            if (abort_after >= 0 && got_data.size() == abort_after) break;
            if (cyc >= 400) begin timeout = 1; break; end
            in_valid  = (rows >= ROW) ? 1'b1 : ((vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0));
            in_row    = row_bits((rows < ROW) ? rows : ROW - 1);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
            start     = noise && busy && ($urandom_range(0, 3) == 0);
            if (in_valid && in_ready) begin
                acc_cnt++; rows++;
                if (rows == ROW) acc_edge = cyc + 1;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data); got_last.push_back(out_last);
                if (out_last) last_edge = cyc + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data; prev_l = out_last;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (in_ready !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: got ready=%b busy=%b want 0 0", in_ready, busy); end
    endtask

    task automatic test_full_frame();
        set_matrix(0, 0);
        run_frame(0, 0, 1'b0, -1);
        tests_run++; if (timeout != 0) begin tests_failed++; $display("FAIL full_timeout: got %0d want 0", timeout); end
        tests_run++; if (got_data.size() != NBEATS) begin tests_failed++; $display("FAIL full_beats: got %0d want %0d", got_data.size(), NBEATS); end
        for (int b = 0; b < got_data.size() && b < NBEATS; b++) begin
            tests_run++; if (got_data[b] !== exp_beat(b)) begin tests_failed++; $display("FAIL full_data[%0d]: got %h want %h", b, got_data[b], exp_beat(b)); end
            tests_run++; if (got_last[b] !== (b == NBEATS-1)) begin tests_failed++; $display("FAIL full_last[%0d]: got %b want %b", b, got_last[b], b == NBEATS-1); end
        end
        if (got_data.size() > 0) begin
            tests_run++; if (got_data[0][31:16] !== 16'h0001 || got_data[0][255:240] !== 16'h0033) begin
                tests_failed++; $display("FAIL full_anchor: got %h/%h want 0001/0033", got_data[0][31:16], got_data[0][255:240]); end
        end
        tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL full_latency: got %0d want 2", lat); end
        tests_run++; if (done_cycle != last_edge || last_edge < 0) begin tests_failed++; $display("FAIL full_done_time: got %0d want %0d", done_cycle, last_edge); end
        tests_run++; if (done_pulses != 1) begin tests_failed++; $display("FAIL full_done_width: got %0d want 1", done_pulses); end
        tests_run++; if (acc_cnt != ROW) begin tests_failed++; $display("FAIL full_accepts: got %0d want %0d", acc_cnt, ROW); end
        tests_run++; if (busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL full_idle: got busy=%b valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_backpressure();
        set_matrix(0, 0);
        run_frame(0, 1, 1'b0, -1);
        tests_run++; if (got_data.size() != NBEATS || timeout != 0) begin tests_failed++; $display("FAIL bp_beats: got %0d want %0d", got_data.size(), NBEATS); end
        for (int b = 0; b < got_data.size() && b < NBEATS; b++) begin
            tests_run++; if (got_data[b] !== exp_beat(b) || got_last[b] !== (b == NBEATS-1)) begin
                tests_failed++; $display("FAIL bp_data[%0d]: got %h last %b want %h", b, got_data[b], got_last[b], exp_beat(b)); end
        end
        tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
        tests_run++; if (done_pulses != 1) begin tests_failed++; $display("FAIL bp_done: got %0d want 1", done_pulses); end
    endtask

    task automatic test_input_gaps();
        for (int it = 0; it < 3; it++) begin
            set_matrix(1, 0);
            run_frame(1, 2, 1'b0, -1);
            tests_run++; if (acc_cnt != ROW || timeout != 0) begin tests_failed++; $display("FAIL gaps_accepts[%0d]: got %0d want %0d", it, acc_cnt, ROW); end
            tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL gaps_latency[%0d]: got %0d want 2", it, lat); end
            tests_run++; if (got_data.size() != NBEATS) begin tests_failed++; $display("FAIL gaps_beats[%0d]: got %0d want %0d", it, got_data.size(), NBEATS); end
            for (int b = 0; b < got_data.size() && b < NBEATS; b++) begin
                tests_run++; if (got_data[b] !== exp_beat(b) || got_last[b] !== (b == NBEATS-1)) begin
                    tests_failed++; $display("FAIL gaps_data[%0d][%0d]: got %h want %h", it, b, got_data[b], exp_beat(b)); end
            end
            tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL gaps_stable[%0d]: got %0d want 0", it, stab_err); end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            set_matrix(0, f * 128);
            run_frame(f, 2, 1'b1, -1);
            tests_run++; if (got_data.size() != NBEATS || timeout != 0) begin tests_failed++; $display("FAIL b2b_beats[%0d]: got %0d want %0d", f, got_data.size(), NBEATS); end
            for (int b = 0; b < got_data.size() && b < NBEATS; b++) begin
                tests_run++; if (got_data[b] !== exp_beat(b) || got_last[b] !== (b == NBEATS-1)) begin
                    tests_failed++; $display("FAIL b2b_data[%0d][%0d]: got %h want %h", f, b, got_data[b], exp_beat(b)); end
            end
            tests_run++; if (acc_cnt != ROW || done_pulses != 1) begin tests_failed++; $display("FAIL b2b_ctrl[%0d]: got accepts %0d done %0d want %0d 1", f, acc_cnt, done_pulses, ROW); end
        end
    endtask

    task automatic test_reset_mid_drain();
        set_matrix(0, 0);
        run_frame(0, 0, 1'b0, 2);
        tests_run++; if (got_data.size() != 2 || timeout != 0) begin tests_failed++; $display("FAIL abort_beats: got %0d want 2", got_data.size()); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_drop: got valid=%b busy=%b want 0 0", out_valid, busy); end
        tests_run++; if (in_ready !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got ready=%b done=%b last=%b want 0 0 0", in_ready, done, out_last); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 0, 1'b0, -1);
        tests_run++; if (got_data.size() != NBEATS || timeout != 0) begin tests_failed++; $display("FAIL after_abort_beats: got %0d want %0d", got_data.size(), NBEATS); end
        for (int b = 0; b < got_data.size() && b < NBEATS; b++) begin
            tests_run++; if (got_data[b] !== exp_beat(b) || got_last[b] !== (b == NBEATS-1)) begin
                tests_failed++; $display("FAIL after_abort_data[%0d]: got %h want %h", b, got_data[b], exp_beat(b)); end
        end
        tests_run++; if (lat != 2 || done_pulses != 1) begin tests_failed++; $display("FAIL after_abort_timing: got lat %0d done %0d want 2 1", lat, done_pulses); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_input_gaps();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
